// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel push-button conditioner.
// Each channel normalises pad polarity, synchronises into clk, debounces with a
// lock-out window, and produces a clean level plus press/release, long-press
// and auto-repeat strobes. Every output is a registered signal in the clk domain.

module debounce_bank #(
  parameter int CHANNELS      = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int HOLD_CYCLES   = 262144,
  parameter int LONG_CYCLES   = 27000000,
  parameter int REPEAT_CYCLES = 5400000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_raw,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_p,
  output logic [CHANNELS-1:0] long_press,
  output logic [CHANNELS-1:0] repeat_p
);

  // Parameter sanity checks, reported while the design is elaborated.
  if (CHANNELS < 1) begin : g_bad_channels
    $error("debounce_bank: CHANNELS must be at least 1");
  end
  if (HOLD_CYCLES < 2) begin : g_bad_hold
    $error("debounce_bank: HOLD_CYCLES must be at least 2");
  end
  if (LONG_CYCLES <= HOLD_CYCLES) begin : g_bad_long
    $error("debounce_bank: LONG_CYCLES must exceed HOLD_CYCLES");
  end
  // The repeat reload value LONG-REPEAT+1 must stay non-negative.
  if (REPEAT_CYCLES < 0 || REPEAT_CYCLES > LONG_CYCLES) begin : g_bad_repeat
    $error("debounce_bank: REPEAT_CYCLES must lie in 0..LONG_CYCLES");
  end

  // Lock counter only needs to reach HOLD_CYCLES-1.
  localparam int LOCK_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);
  // One value of headroom above LONG_CYCLES so the no-repeat stop value
  // LONG_CYCLES+1 always fits, even when LONG_CYCLES+1 is a power of two.
  localparam int TIMER_W = $clog2(LONG_CYCLES + 2);

  localparam logic [LOCK_W-1:0]  LOCK_ONE   = LOCK_W'(1);
  localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] LONG_VAL   = TIMER_W'(LONG_CYCLES);
  localparam logic [TIMER_W-1:0] STOP_VAL   = TIMER_W'(LONG_CYCLES + 1);
  localparam logic [TIMER_W-1:0] RELOAD_VAL = TIMER_W'(LONG_CYCLES - REPEAT_CYCLES + 1);
  localparam bit                 REPEAT_EN  = (REPEAT_CYCLES > 0);

  typedef enum logic {
    S_IDLE,
    S_LOCK
  } state_t;

  // Internally a 1 always means "pressed", whatever the pad polarity.
  logic [CHANNELS-1:0] btn_norm;
  assign btn_norm = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic               sync1, sync2;
    state_t             state, state_next;
    logic [LOCK_W-1:0]  lock_cnt, lock_cnt_next;
    logic               level_q, level_next;
    logic               press_q, press_next;
    logic               release_q, release_next;
    logic [TIMER_W-1:0] timer, timer_next;
    logic               long_done;
    logic               long_q, repeat_q;
    logic               hit;

    // Two-flop synchroniser; resets to the released state.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
      end else begin
        sync1 <= btn_norm[g];
        sync2 <= sync1;
      end
    end

    // Debounce state register together with the level and edge strobes.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state     <= S_IDLE;
        lock_cnt  <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_next;
        lock_cnt  <= lock_cnt_next;
        level_q   <= level_next;
        press_q   <= press_next;
        release_q <= release_next;
      end
    end

    // Accept a change only when idle, then ignore the input for the lock-out window.
    always_comb begin
      state_next    = state;
      lock_cnt_next = lock_cnt;
      level_next    = level_q;
      press_next    = 1'b0;
      release_next  = 1'b0;
      case (state)
        S_IDLE: begin
          if (sync2 != level_q) begin
            level_next    = sync2;
            press_next    = sync2;
            release_next  = ~sync2;
            lock_cnt_next = LOCK_ONE;
            state_next    = S_LOCK;
          end
        end
        S_LOCK: begin
          if (lock_cnt == LOCK_LAST) begin
            lock_cnt_next = '0;
            state_next    = S_IDLE;
          end else begin
            lock_cnt_next = lock_cnt + LOCK_ONE;
          end
        end
        default: begin
          lock_cnt_next = '0;
          state_next    = S_IDLE;
        end
      endcase
    end

    // Next hold-timer value: count up, reload after a strobe, or park past LONG.
    always_comb begin
      timer_next = timer + TIMER_ONE;
      if (REPEAT_EN) begin
        if (timer == LONG_VAL) begin
          timer_next = RELOAD_VAL;
        end
      end else if (timer == STOP_VAL) begin
        timer_next = timer;
      end
      hit = level_q && level_next && (timer_next == LONG_VAL);
    end

    // Hold timer and long/repeat strobes; the first hit is long_press, later hits repeat.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        timer     <= '0;
        long_done <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else if (!level_next) begin
        timer     <= '0;
        long_done <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        if (level_q) begin
          timer <= timer_next;
        end
        long_q   <= hit && !long_done;
        repeat_q <= hit && long_done;
        if (hit) begin
          long_done <= 1'b1;
        end
      end
    end

    assign level[g]      = level_q;
    assign press[g]      = press_q;
    assign release_p[g]  = release_q;
    assign long_press[g] = long_q;
    assign repeat_p[g]   = repeat_q;
  end

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed stimulus for debounce_bank with a behavioural model.
// Two instances share the pads: one with auto-repeat, one with repeat disabled.

module tb_debounce_bank;

  localparam int CH     = 2;
  localparam int HOLD   = 8;
  localparam int LONG   = 40;
  localparam int REPEAT = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] btn_raw = 2'b11;

  logic [CH-1:0] level_a, press_a, rel_a, long_a, rep_a;
  logic [CH-1:0] level_b, press_b, rel_b, long_b, rep_b;

  int n_cmp  = 0;
  int n_fail = 0;

  debounce_bank #(
    .CHANNELS(CH), .ACTIVE_LOW(1), .HOLD_CYCLES(HOLD),
    .LONG_CYCLES(LONG), .REPEAT_CYCLES(REPEAT)
  ) dut_a (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .level(level_a), .press(press_a), .release_p(rel_a),
    .long_press(long_a), .repeat_p(rep_a)
  );

  debounce_bank #(
    .CHANNELS(CH), .ACTIVE_LOW(1), .HOLD_CYCLES(HOLD),
    .LONG_CYCLES(LONG), .REPEAT_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .level(level_b), .press(press_b), .release_p(rel_b),
    .long_press(long_b), .repeat_p(rep_b)
  );

  // 10 time-unit clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at t=%0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [CH-1:0] raw);
    btn_raw = raw;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Behavioural model: level follows the input seen two edges earlier, but no two
  // level changes closer than HOLD edges; strobes derive from edges since press.
  int  edge_no      = 0;
  bit  m_s1  [CH]   = '{default: 1'b0};
  bit  m_s2  [CH]   = '{default: 1'b0};
  bit  m_lvl [CH]   = '{default: 1'b0};
  int  last_chg [CH] = '{default: -1000};
  int  press_at [CH] = '{default: 0};
  logic [CH-1:0] e_level = '0, e_press = '0, e_rel = '0, e_long = '0;
  logic [CH-1:0] e_rep_a = '0, e_rep_b = '0;

  // Model update on every active edge, reset asynchronously with the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_lvl[c] = 1'b0;
        last_chg[c] = -1000; press_at[c] = 0;
      end
      e_level = '0; e_press = '0; e_rel = '0; e_long = '0; e_rep_a = '0; e_rep_b = '0;
    end else begin
      edge_no++;
      for (int c = 0; c < CH; c++) begin
        bit changed;
        int since;
        changed = (m_s2[c] != m_lvl[c]) && ((edge_no - last_chg[c]) >= HOLD);
        if (changed) begin
          m_lvl[c]    = m_s2[c];
          last_chg[c] = edge_no;
          if (m_lvl[c]) press_at[c] = edge_no;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = ~btn_raw[c];
        since = edge_no - press_at[c];
        e_level[c] = m_lvl[c];
        e_press[c] = changed && m_lvl[c];
        e_rel[c]   = changed && !m_lvl[c];
        e_long[c]  = m_lvl[c] && (since == LONG);
        e_rep_a[c] = m_lvl[c] && (since > LONG) && (((since - LONG) % REPEAT) == 0);
        e_rep_b[c] = 1'b0;
      end
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    check_output("level_a", level_a, e_level);
    check_output("press_a", press_a, e_press);
    check_output("release_a", rel_a, e_rel);
    check_output("long_a", long_a, e_long);
    check_output("repeat_a", rep_a, e_rep_a);
    check_output("level_b", level_b, e_level);
    check_output("press_b", press_b, e_press);
    check_output("release_b", rel_b, e_rel);
    check_output("long_b", long_b, e_long);
    check_output("repeat_b", rep_b, e_rep_b);
  end

  int   n_press   = 0;
  int   n_long_b  = 0;
  int   n_rep_a   = 0;
  int   n_rep_b   = 0;
  logic [6:0] bounce_seq = 7'b0101010;

  // Directed scenario with hand-computed expectations at the key cycles.
  initial begin
    $display("[TB] start");
    tick(3);
    check_output("reset_level", level_a, 2'b00);
    check_output("reset_press", press_a, 2'b00);
    check_output("reset_long", long_a, 2'b00);
    rst = 1'b0;
    tick(100);
    check_output("idle_level", level_a, 2'b00);

    // Clean press and release on channel 0.
    apply_stimulus(2'b10);
    tick(2);
    check_output("clean_pre_level", level_a, 2'b00);
    tick(1);
    check_output("clean_level", level_a, 2'b01);
    check_output("clean_press", press_a, 2'b01);
    tick(1);
    check_output("clean_press_end", press_a, 2'b00);
    tick(16);
    apply_stimulus(2'b11);
    tick(2);
    check_output("clean_rel_pre", level_a, 2'b01);
    tick(1);
    check_output("clean_rel_level", level_a, 2'b00);
    check_output("clean_release", rel_a, 2'b01);
    tick(1);
    check_output("clean_release_end", rel_a, 2'b00);
    tick(12);

    // Bouncy press on channel 0, released four cycles after the press strobe.
    n_press = 0;
    for (int i = 0; i < 11; i++) begin
      apply_stimulus({1'b1, (i < 7) ? bounce_seq[i] : 1'b1});
      tick(1);
      if (press_a[0]) n_press++;
      if (i == 9) check_output("bounce_lock_level", level_a, 2'b01);
      if (i == 10) begin
        check_output("bounce_late_level", level_a, 2'b00);
        check_output("bounce_late_release", rel_a, 2'b01);
      end
    end
    check_output("bounce_press_count", n_press, 1);
    tick(12);

    // Channel 1 long press with auto-repeat, released at +75.
    apply_stimulus(2'b01);
    tick(3);
    check_output("long_press_strobe", press_a, 2'b10);
    tick(40);
    check_output("long_a_at40", long_a, 2'b10);
    check_output("long_b_at40", long_b, 2'b10);
    tick(1);
    check_output("long_a_at41", long_a, 2'b00);
    tick(9);
    check_output("repeat_a_at50", rep_a, 2'b10);
    check_output("repeat_b_at50", rep_b, 2'b00);
    tick(25);
    apply_stimulus(2'b11);
    tick(3);
    check_output("long_rel_level", level_a, 2'b00);
    check_output("long_rel_strobe", rel_a, 2'b10);
    tick(20);

    // Channel 1 released just before long press would fire.
    apply_stimulus(2'b01);
    tick(3);
    check_output("short_press", press_a, 2'b10);
    tick(37);
    apply_stimulus(2'b11);
    tick(2);
    check_output("short_level39", level_a, 2'b10);
    check_output("short_long39", long_a, 2'b00);
    tick(1);
    check_output("short_level40", level_a, 2'b00);
    check_output("short_release40", rel_a, 2'b10);
    check_output("short_long40", long_a, 2'b00);
    tick(20);

    // Both channels pressed on the same edge.
    apply_stimulus(2'b00);
    tick(3);
    check_output("dual_press", press_a, 2'b11);
    check_output("dual_level", level_a, 2'b11);
    tick(40);
    check_output("dual_long_a", long_a, 2'b11);
    check_output("dual_long_b", long_b, 2'b11);
    tick(10);
    check_output("dual_repeat_a", rep_a, 2'b11);
    check_output("dual_repeat_b", rep_b, 2'b00);
    tick(10);

    // Reset pulse while both buttons stay held.
    rst = 1'b1;
    #1;
    check_output("rst_level_a", level_a, 2'b00);
    check_output("rst_level_b", level_b, 2'b00);
    check_output("rst_repeat_a", rep_a, 2'b00);
    tick(2);
    rst = 1'b0;
    tick(2);
    check_output("rst_press_pre", press_a, 2'b00);
    tick(1);
    check_output("rst_press", press_a, 2'b11);
    check_output("rst_level", level_a, 2'b11);

    // Hold 100 cycles: one long press everywhere, repeats only on the repeat instance.
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (long_b[0]) n_long_b++;
      if (rep_b[0])  n_rep_b++;
      if (rep_a[0])  n_rep_a++;
    end
    check_output("norep_long_count", n_long_b, 1);
    check_output("norep_repeat_count", n_rep_b, 0);
    check_output("rep_repeat_count", n_rep_a, 6);
    apply_stimulus(2'b11);
    tick(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
